// File: rtl/deco_fetch_sequencer.sv
// deco_fetch_sequencer
//
// Drives the sequential fetch PC into the instruction decompressor. Each
// decompressed instruction is captured a fixed DECO_LAT edges after its PC was
// issued and is buffered in a small first-word-fall-through FIFO. The CPU takes
// instructions over a valid/ready handshake. The block also handles redirects
// (flush and restart) and stops after END_PC has been fetched.
//
// Ports:
//   clk          clock, all state on the rising edge
//   reset        asynchronous active-low reset
//   start        pulse: begin fetching at start_pc (honoured in idle/done only)
//   start_pc     initial PC
//   redirect     pulse: flush and restart at redirect_pc (honoured while busy)
//   redirect_pc  redirect target
//   deco_pc      registered PC presented to the decompressor
//   deco_instr   decompressed instruction returned by the decompressor
//   instr_valid  FIFO head valid
//   instr_ready  CPU accepts the FIFO head
//   instr_data   FIFO head instruction
//   instr_pc     PC of the FIFO head
//   busy         fetching or draining
//   done         program fetched and fully drained
module deco_fetch_sequencer #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(4),
  parameter int unsigned      DECO_LAT = 1,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] END_PC   = WIDTH'(32'h1BC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] start_pc,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] deco_pc,
  input  logic [WIDTH-1:0] deco_instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr_data,
  output logic [WIDTH-1:0] instr_pc,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IfW  = $clog2(DECO_LAT + 1);
  localparam int unsigned SumW = $clog2(DEPTH + DECO_LAT + 1);

  // The last issue is the one after which pc would step past END_PC. When
  // END_PC < PC_STEP every issue is the last one (and the subtraction would wrap).
  localparam bit               EndBelowStep = (END_PC < PC_STEP);
  localparam logic [WIDTH-1:0] LastThresh   = END_PC - PC_STEP;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    pc_q, pc_d;
  logic [WIDTH-1:0]    deco_pc_q, deco_pc_d;

  // Tag pipeline: stage 0 is loaded on issue, stage DECO_LAT-1 exits into the FIFO.
  logic [DECO_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [WIDTH-1:0]    tag_pc_q [DECO_LAT];
  logic [WIDTH-1:0]    tag_pc_d [DECO_LAT];

  logic [WIDTH-1:0]    fifo_data_q [DEPTH];
  logic [WIDTH-1:0]    fifo_pc_q   [DEPTH];
  logic [CntW-1:0]     count_q, count_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;

  logic [IfW-1:0]      inflight;
  logic                credit_ok;
  logic                flush;
  logic                issue;
  logic                push;
  logic                pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(DECO_LAT); i++) begin
      inflight = inflight + IfW'(tag_vld_q[i]);
    end
  end

  // Credit uses the registered occupancy only; a pop on this edge frees a slot
  // that becomes usable one edge later.
  assign credit_ok = (SumW'(count_q) + SumW'(inflight)) < SumW'(DEPTH);

  assign flush = redirect && ((state_q == StFetch) || (state_q == StDrain));
  assign pop   = (count_q != '0) && instr_ready;
  assign push  = tag_vld_q[DECO_LAT-1] && !flush;

  // Control FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    issue   = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          pc_d    = start_pc;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (flush) begin
          pc_d    = redirect_pc;
          state_d = StFetch;
        end else if (pc_q > END_PC) begin
          state_d = StDrain;
        end else if (credit_ok) begin
          issue = 1'b1;
          pc_d  = pc_q + PC_STEP;
          if (EndBelowStep || (pc_q > LastThresh)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (flush) begin
          pc_d    = redirect_pc;
          state_d = StFetch;
        end else if ((inflight == '0) && (count_q == '0)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next state: issue register, tag pipeline and FIFO bookkeeping.
  always_comb begin
    deco_pc_d = issue ? pc_q : deco_pc_q;

    tag_vld_d[0] = issue;
    tag_pc_d[0]  = pc_q;
    for (int i = 1; i < int'(DECO_LAT); i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_pc_d[i]  = tag_pc_q[i-1];
    end
    if (flush) begin
      tag_vld_d = '0;
    end

    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (!push && pop) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      deco_pc_q <= '0;
      tag_vld_q <= '0;
      for (int i = 0; i < int'(DECO_LAT); i++) begin
        tag_pc_q[i] <= '0;
      end
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      deco_pc_q <= deco_pc_d;
      tag_vld_q <= tag_vld_d;
      for (int i = 0; i < int'(DECO_LAT); i++) begin
        tag_pc_q[i] <= tag_pc_d[i];
      end
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // FIFO storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= deco_instr;
      fifo_pc_q[wr_ptr_q]   <= tag_pc_q[DECO_LAT-1];
    end
  end

  assign deco_pc     = deco_pc_q;
  assign instr_valid = (count_q != '0);
  // Head is gated so stale storage never shows while the FIFO is empty.
  assign instr_data  = instr_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q] : '0;
  assign busy        = (state_q == StFetch) || (state_q == StDrain);
  assign done        = (state_q == StDone);

endmodule

// File: tb/tb_deco_fetch_sequencer.sv
// Testbench for deco_fetch_sequencer: directed scenarios with randomized CPU
// back-pressure, checked against an arithmetic model of the expected stream.
module tb_deco_fetch_sequencer;

  localparam logic [31:0] EndPc = 32'h1BC;
  localparam logic [31:0] Xor   = 32'hA5A50000;
  localparam int          Depth = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] start_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] deco_pc;
  logic [31:0] deco_instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  // Model state: next PC the CPU must see, issue/pop counts, cycle counter.
  logic [31:0] exp_pc;
  logic [31:0] last_deco;
  int          issued_n;
  int          popped_n;
  int          cyc;
  int          first_pop_cyc;
  int          last_pop_cyc;
  bit          rand_ready;

  deco_fetch_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_pc   (start_pc),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .deco_pc    (deco_pc),
    .deco_instr (deco_instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_data (instr_data),
    .instr_pc   (instr_pc),
    .busy       (busy),
    .done       (done)
  );

  // Stub decompressor: result for deco_pc is ready by the next edge.
  assign deco_instr = deco_pc ^ Xor;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic begin_run(input logic [31:0] first_pc);
    exp_pc        = first_pc;
    issued_n      = 0;
    popped_n      = 0;
    last_deco     = deco_pc;
    first_pop_cyc = -1;
    last_pop_cyc  = -1;
  endtask

  // One clock: score any handshake offered now, then advance to edge + 1.
  task automatic tick();
    if (instr_valid && instr_ready) begin
      check("in_range", 32'(exp_pc <= EndPc), 32'd1);
      check("head_pc", instr_pc, exp_pc);
      check("head_data", instr_data, exp_pc ^ Xor);
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      exp_pc = exp_pc + 32'd4;
      popped_n++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (deco_pc !== last_deco) begin
      issued_n++;
      last_deco = deco_pc;
      check("deco_pc_le_end", 32'(deco_pc <= EndPc), 32'd1);
    end
    check("outstanding", 32'((issued_n - popped_n) <= Depth), 32'd1);
  endtask

  task automatic drive_ready();
    instr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      drive_ready();
      tick();
      n++;
    end
    check("done_in_budget", 32'(done), 32'd1);
  endtask

  task automatic pulse_start(input logic [31:0] pc);
    start_pc = pc;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    start_pc    = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    rand_ready  = 1'b0;
    cyc         = 0;
    begin_run(32'h0);

    // Reset state.
    #12;
    check("rst_deco_pc", deco_pc, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_data", instr_data, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Redirect in idle is ignored.
    redirect_pc = 32'h100;
    redirect    = 1'b1;
    tick();
    redirect = 1'b0;
    check("idle_redir_busy", 32'(busy), 32'd0);
    tick();
    check("idle_redir_busy2", 32'(busy), 32'd0);
    check("idle_redir_deco", deco_pc, 32'h0);

    // Full run, ready held high, with a stray start pulse mid-fetch.
    instr_ready = 1'b1;
    begin_run(32'h0);
    pulse_start(32'h0);
    check("fetch_busy", 32'(busy), 32'd1);
    tick();
    check("e1_valid", 32'(instr_valid), 32'd0);
    check("e1_deco", deco_pc, 32'h0);
    tick();
    check("e2_valid", 32'(instr_valid), 32'd1);
    check("e2_pc", instr_pc, 32'h0);
    repeat (10) tick();
    pulse_start(32'h80);
    wait_done(400);
    check("run1_count", 32'(popped_n), 32'd112);
    check("run1_last_pc", exp_pc - 32'd4, EndPc);
    check("run1_gapless", 32'(last_pop_cyc - first_pop_cyc), 32'd111);
    check("run1_last_deco", deco_pc, EndPc);
    repeat (3) tick();
    check("done_sticky", 32'(done), 32'd1);

    // Back-pressure: ready low from the start, then random release.
    instr_ready = 1'b0;
    begin_run(32'h0);
    pulse_start(32'h0);
    repeat (8) tick();
    check("bp_deco", deco_pc, 32'hC);
    check("bp_valid", 32'(instr_valid), 32'd1);
    check("bp_head_pc", instr_pc, 32'h0);
    check("bp_head_data", instr_data, Xor);
    repeat (3) tick();
    check("bp_deco_hold", deco_pc, 32'hC);
    check("bp_head_stable", instr_pc, 32'h0);
    rand_ready = 1'b1;
    wait_done(1000);
    check("bp_count", 32'(popped_n), 32'd112);

    // Redirect with two buffered and one in flight.
    rand_ready  = 1'b0;
    instr_ready = 1'b0;
    begin_run(32'h0);
    pulse_start(32'h0);
    repeat (3) tick();
    check("pre_redir_deco", deco_pc, 32'h8);
    check("pre_redir_valid", 32'(instr_valid), 32'd1);
    redirect_pc = 32'h100;
    redirect    = 1'b1;
    begin_run(32'h100);
    tick();
    redirect = 1'b0;
    check("redir_flushed", 32'(instr_valid), 32'd0);
    check("redir_busy", 32'(busy), 32'd1);
    check("redir_no_issue", deco_pc, 32'h8);
    tick();
    check("redir_first_issue", deco_pc, 32'h100);
    instr_ready = 1'b1;
    wait_done(400);
    check("redir_count", 32'(popped_n), 32'd48);

    // Asynchronous reset between edges mid-fetch.
    instr_ready = 1'b1;
    begin_run(32'h0);
    pulse_start(32'h0);
    repeat (5) tick();
    #2;
    reset = 1'b0;
    #1;
    check("arst_deco", deco_pc, 32'h0);
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_data", instr_data, 32'h0);
    check("arst_pc", instr_pc, 32'h0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("arst_idle_done", 32'(done), 32'd0);
    rand_ready = 1'b1;
    begin_run(32'h40);
    pulse_start(32'h40);
    wait_done(1000);
    check("restart_first", 32'(popped_n > 0), 32'd1);
    check("restart_count", 32'(popped_n), 32'd96);

    // Start beyond END_PC.
    do_reset();
    rand_ready  = 1'b0;
    instr_ready = 1'b1;
    begin_run(32'h1C0);
    pulse_start(32'h1C0);
    tick();
    check("past_end_busy", 32'(busy), 32'd1);
    tick();
    check("past_end_done", 32'(done), 32'd1);
    check("past_end_valid", 32'(instr_valid), 32'd0);
    check("past_end_deco", deco_pc, 32'h0);
    check("past_end_pops", 32'(popped_n), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
